ifmap_read_sequencer: RTL and testbench

//   Read-side controller for the 16-bank ifmap BRAM block. Generates the conv and transconv

---
 rtl/ifmap_seq_pkg.sv | 51 +++++
 rtl/ifmap_seq_counter.sv | 48 ++++
 rtl/ifmap_read_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_ifmap_read_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ifmap_seq_pkg.sv
// Shared constants, state encoding and helpers for the ifmap read sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ifmap_seq_pkg;

  localparam int IFM_NUM_BRAMS = 16;
  localparam int IFM_ADDR_W    = 10;
  localparam int IFM_LEN_W     = IFM_ADDR_W + 1;
  localparam int SEL_W         = 4;
  localparam int NBANK_W       = 5;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_START = ST_START,
    S_RUN   = ST_RUN,
    S_DRAIN = ST_DRAIN,
    S_DONE  = ST_DONE
  } state_t;

  localparam logic MODE_CONV      = 1'b0;
  localparam logic MODE_TRANSCONV = 1'b1;

  // Highest bank index swept per address: 0 behaves as 1 bank, >16 as 16 banks.
  function automatic logic [SEL_W-1:0] nbank_to_sel_max(input logic [NBANK_W-1:0] nb);
    logic [NBANK_W-1:0] m1;
    m1 = nb - NBANK_W'(1);
    if (nb == '0)
      return '0;
    else if (nb > NBANK_W'(16))
      return SEL_W'(15);
    else
      return m1[SEL_W-1:0];
  endfunction

  // Index of the set bit in a one-hot bank enable vector.
  function automatic logic [SEL_W-1:0] onehot_to_sel(input logic [IFM_NUM_BRAMS-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < IFM_NUM_BRAMS; i++) begin
      if (oh[i]) idx = idx | SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ifmap_seq_counter.sv
// Two-level read counter: bank select inner loop, address offset outer loop.
// Latency: counts advance on the edge where i_en is high; o_last is combinational.
// Backpressure: i_en low holds both levels (used for stall).
// Ports: i_clr zeroes both levels; i_sel_max / i_addr_max are inclusive wrap
// limits; o_last flags the final (sel, addr) pair of the sweep.
module ifmap_seq_counter #(
  parameter int SEL_W = 4,
  parameter int CNT_W = 11
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [SEL_W-1:0] i_sel_max,
  input  logic [CNT_W-1:0] i_addr_max,
  output logic [SEL_W-1:0] o_sel,
  output logic [CNT_W-1:0] o_addr,
  output logic             o_last
);

  logic [SEL_W-1:0] r_sel;
  logic [CNT_W-1:0] r_addr;
  logic             w_sel_wrap;

  assign w_sel_wrap = (r_sel == i_sel_max);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sel  <= '0;
      r_addr <= '0;
    end else if (i_clr) begin
      r_sel  <= '0;
      r_addr <= '0;
    end else if (i_en) begin
      if (w_sel_wrap) begin
        r_sel  <= '0;
        r_addr <= r_addr + CNT_W'(1);
      end else begin
        r_sel <= r_sel + SEL_W'(1);
      end
    end
  end

  assign o_sel  = r_sel;
  assign o_addr = r_addr;
  assign o_last = w_sel_wrap && (r_addr == i_addr_max);

endmodule

// File: rtl/ifmap_read_sequencer.sv
// Read-side controller for the 16-bank ifmap BRAM: mode pulses, conv/transconv
// read enables + addresses, dob-aligned bank select and data-valid strobe.
// Latency: start at edge k -> mode pulse k+1, first read k+2, first data_valid k+3.
// Backpressure: i_stall sampled at a RUN-cycle edge suppresses the read of the
// following cycle and holds the counters; no address is skipped or repeated.
// Ports: i_start/i_abort/i_stall control, i_cfg_* latched on start; o_start_*
// mode pulses, o_if_re_*/o_if_addr_rd_*_flat BRAM read side, o_ifmap_sel_transconv,
// o_data_valid, o_busy, o_done. Every output is a flop, all reset to 0.
module ifmap_read_sequencer
  import ifmap_seq_pkg::*;
#(
  parameter int NUM_BRAMS  = IFM_NUM_BRAMS,
  parameter int ADDR_WIDTH = IFM_ADDR_W,
  parameter int LEN_W      = IFM_LEN_W
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_start,
  input  logic                            i_abort,
  input  logic                            i_stall,
  input  logic                            i_cfg_mode,
  input  logic [ADDR_WIDTH-1:0]           i_cfg_base,
  input  logic [LEN_W-1:0]                i_cfg_len,
  input  logic [NBANK_W-1:0]              i_cfg_nbank,
  output logic                            o_start_conv,
  output logic                            o_start_transconv,
  output logic [NUM_BRAMS-1:0]            o_if_re_conv,
  output logic [NUM_BRAMS*ADDR_WIDTH-1:0] o_if_addr_rd_conv_flat,
  output logic [NUM_BRAMS-1:0]            o_if_re_transconv,
  output logic [NUM_BRAMS*ADDR_WIDTH-1:0] o_if_addr_rd_transconv_flat,
  output logic [SEL_W-1:0]                o_ifmap_sel_transconv,
  output logic                            o_data_valid,
  output logic                            o_busy,
  output logic                            o_done
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_go;
  logic                  w_issue;

  logic                  r_mode;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [LEN_W-1:0]      r_len;
  logic [SEL_W-1:0]      r_sel_max;
  logic                  r_all_issued;

  logic [SEL_W-1:0]      w_cnt_sel;
  logic [LEN_W-1:0]      w_cnt_addr;
  logic                  w_cnt_last;
  logic [LEN_W-1:0]      w_len_m1;
  logic [ADDR_WIDTH-1:0] w_rd_addr;

  logic                  r_start_conv;
  logic                  r_start_tc;
  logic [NUM_BRAMS-1:0]  r_re_conv;
  logic [ADDR_WIDTH-1:0] r_addr_conv;
  logic [NUM_BRAMS-1:0]  r_re_tc;
  logic [ADDR_WIDTH-1:0] r_addr_tc;
  logic [SEL_W-1:0]      r_sel_out;
  logic                  r_data_valid;
  logic                  r_busy;
  logic                  r_done;

  assign w_len_m1  = r_len - LEN_W'(1);
  // Address arithmetic deliberately wraps at the top of the BRAM.
  assign w_rd_addr = r_base + ADDR_WIDTH'(w_cnt_addr);

  ifmap_seq_counter #(
    .SEL_W (SEL_W),
    .CNT_W (LEN_W)
  ) u_counter (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (w_go),
    .i_en       (w_issue),
    .i_sel_max  (r_sel_max),
    .i_addr_max (w_len_m1),
    .o_sel      (w_cnt_sel),
    .o_addr     (w_cnt_addr),
    .o_last     (w_cnt_last)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Outputs are registered from this decision, so the state seen in a cycle
  // matches what the outputs show in that cycle (RUN cycles carry the reads).
  always_comb begin
    w_state_nxt = r_state;
    w_go        = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_go        = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (r_len == '0) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_issue     = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (r_all_issued) w_state_nxt = S_DRAIN;
        else if (!i_stall) w_issue = 1'b1;
      end
      S_DRAIN: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_issue     = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode       <= MODE_CONV;
      r_base       <= '0;
      r_len        <= '0;
      r_sel_max    <= '0;
      r_all_issued <= 1'b0;
    end else if (w_go) begin
      r_mode       <= i_cfg_mode;
      r_base       <= i_cfg_base;
      r_len        <= i_cfg_len;
      r_sel_max    <= (i_cfg_mode == MODE_TRANSCONV) ? nbank_to_sel_max(i_cfg_nbank) : '0;
      r_all_issued <= 1'b0;
    end else if (w_issue && w_cnt_last) begin
      r_all_issued <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_start_conv <= 1'b0;
      r_start_tc   <= 1'b0;
      r_re_conv    <= '0;
      r_addr_conv  <= '0;
      r_re_tc      <= '0;
      r_addr_tc    <= '0;
      r_sel_out    <= '0;
      r_data_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_start_conv <= w_go && (i_cfg_mode == MODE_CONV);
      r_start_tc   <= w_go && (i_cfg_mode == MODE_TRANSCONV);
      r_re_conv    <= {NUM_BRAMS{w_issue && (r_mode == MODE_CONV)}};
      r_addr_conv  <= (w_issue && (r_mode == MODE_CONV)) ? w_rd_addr : '0;
      r_re_tc      <= (w_issue && (r_mode == MODE_TRANSCONV)) ? (NUM_BRAMS'(1) << w_cnt_sel) : '0;
      r_addr_tc    <= (w_issue && (r_mode == MODE_TRANSCONV)) ? w_rd_addr : '0;
      // BRAM read latency is one cycle: dob of this cycle's read lands next cycle.
      r_data_valid <= (|r_re_conv) || (|r_re_tc);
      if (|r_re_tc) r_sel_out <= onehot_to_sel(r_re_tc);
      r_busy       <= (w_state_nxt != S_IDLE);
      r_done       <= (w_state_nxt == S_DONE);
    end
  end

  assign o_start_conv                = r_start_conv;
  assign o_start_transconv           = r_start_tc;
  assign o_if_re_conv                = r_re_conv;
  assign o_if_addr_rd_conv_flat      = {NUM_BRAMS{r_addr_conv}};
  assign o_if_re_transconv           = r_re_tc;
  assign o_if_addr_rd_transconv_flat = {NUM_BRAMS{r_addr_tc}};
  assign o_ifmap_sel_transconv       = r_sel_out;
  assign o_data_valid                = r_data_valid;
  assign o_busy                      = r_busy;
  assign o_done                      = r_done;

endmodule

// File: tb/tb_ifmap_read_sequencer.sv
module tb_ifmap_read_sequencer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         stall = 1'b0;
  logic         cfg_mode = 1'b0;
  logic [9:0]   cfg_base = '0;
  logic [10:0]  cfg_len = '0;
  logic [4:0]   cfg_nbank = '0;
  logic         start_conv, start_tc, dv, busy, done;
  logic [15:0]  re_conv, re_tc;
  logic [159:0] addr_conv, addr_tc;
  logic [3:0]   sel_tc;

  ifmap_read_sequencer dut (
    .i_clk                       (clk),
    .i_rst_n                     (rst_n),
    .i_start                     (start),
    .i_abort                     (abort),
    .i_stall                     (stall),
    .i_cfg_mode                  (cfg_mode),
    .i_cfg_base                  (cfg_base),
    .i_cfg_len                   (cfg_len),
    .i_cfg_nbank                 (cfg_nbank),
    .o_start_conv                (start_conv),
    .o_start_transconv           (start_tc),
    .o_if_re_conv                (re_conv),
    .o_if_addr_rd_conv_flat      (addr_conv),
    .o_if_re_transconv           (re_tc),
    .o_if_addr_rd_transconv_flat (addr_tc),
    .o_ifmap_sel_transconv       (sel_tc),
    .o_data_valid                (dv),
    .o_busy                      (busy),
    .o_done                      (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Per-cycle expectation arrays, indexed by cycle offset from the start cycle.
  bit         st[256];
  bit         e_rv[256];
  logic [9:0] e_ra[256];
  int         e_rs[256];
  bit         e_busy[256];
  bit         e_done[256];
  logic [3:0] e_sel[256];
  logic [3:0] prev_sel = '0;

  typedef struct {
    logic        mode;
    logic [9:0]  base;
    logic [10:0] len;
    logic [4:0]  nb;
    logic [31:0] mask;
    int          abort_at;
    int          restart_at;
    int          exp_reads;
    int          exp_done;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int cyc, input logic [383:0] act, input logic [383:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [383:0] all_outputs();
    return {23'd0, start_conv, start_tc, dv, busy, done, sel_tc, re_conv, addr_conv, re_tc, addr_tc};
  endfunction

  // Reference: the job is an ordered list of reads (address-major, bank-minor).
  // Cycle 1 carries the mode pulse; read list entries appear from cycle 2 on,
  // one per cycle, except a cycle whose previous cycle had stall high.
  task automatic run_op(input logic mode, input logic [9:0] base, input logic [10:0] len,
                        input logic [4:0] nb, input int abort_at, input int restart_at,
                        input bit rnd_stall, input logic [31:0] mask,
                        output int n_reads, output int done_at);
    int nbc, n, ptr, t, endc, a_eff, last, busy_end;
    logic [3:0]   s;
    logic [15:0]  one;
    logic [8:0]   act_c, exp_c;
    logic [351:0] act_d, exp_d;
    logic [15:0]  erc, ert;
    logic [9:0]   ea;
    one = 16'd1;
    nbc = mode ? ((nb == 0) ? 1 : ((nb > 16) ? 16 : int'(nb))) : 1;
    n = int'(len) * nbc;
    for (int i = 0; i < 256; i++) begin
      st[i]     = rnd_stall ? ($urandom_range(0, 99) < 30) : ((i < 32) ? mask[i] : 1'b0);
      e_rv[i]   = 1'b0;
      e_ra[i]   = '0;
      e_rs[i]   = 0;
      e_busy[i] = 1'b0;
      e_done[i] = 1'b0;
    end
    if (n == 0) begin
      endc = 3;
    end else begin
      ptr = 0;
      t = 2;
      while (ptr < n && t < 240) begin
        if (t == 2 || !st[t-1]) begin
          e_rv[t] = 1'b1;
          e_ra[t] = base + 10'(ptr / nbc);
          e_rs[t] = ptr % nbc;
          ptr++;
        end
        t++;
      end
      endc = t + 1;
    end
    a_eff = (abort_at >= 1 && abort_at <= endc) ? abort_at : 1000;
    busy_end = (endc < a_eff) ? endc : a_eff;
    last = busy_end + 3;
    for (int j = 0; j < 256; j++) begin
      if (j > a_eff) e_rv[j] = 1'b0;
      e_busy[j] = (j >= 1 && j <= busy_end);
      e_done[j] = (j == endc && endc <= a_eff);
    end
    s = prev_sel;
    for (int j = 0; j <= last; j++) begin
      e_sel[j] = s;
      if (mode && e_rv[j]) s = 4'(e_rs[j]);
    end
    prev_sel = s;

    n_reads = 0;
    done_at = -1;
    for (int j = 0; j <= last; j++) begin
      @(negedge clk);
      act_c = {start_conv, start_tc, dv, busy, done, sel_tc};
      exp_c = {(j == 1) && !mode, (j == 1) && mode, (j >= 1) ? e_rv[j-1] : 1'b0,
               e_busy[j], e_done[j], e_sel[j]};
      erc = (e_rv[j] && !mode) ? 16'hFFFF : 16'h0;
      ert = (e_rv[j] && mode) ? (one << e_rs[j]) : 16'h0;
      ea  = e_ra[j];
      act_d = {re_conv, addr_conv, re_tc, addr_tc};
      exp_d = {erc, (e_rv[j] && !mode) ? {16{ea}} : 160'd0,
               ert, (e_rv[j] && mode) ? {16{ea}} : 160'd0};
      check("ctrl", j, 384'(act_c), 384'(exp_c));
      check("read", j, 384'(act_d), 384'(exp_d));
      if ((|re_conv) || (|re_tc)) n_reads++;
      if (done && done_at < 0) done_at = j;
      // Drive inputs for cycle j; cfg is scrambled after the start cycle to
      // show it was latched.
      start = (j == 0) || (j == restart_at && restart_at >= 1 && restart_at <= busy_end);
      abort = (j == abort_at && abort_at >= 0 && abort_at <= endc);
      stall = st[j];
      if (j == 0) begin
        cfg_mode = mode; cfg_base = base; cfg_len = len; cfg_nbank = nb;
      end else begin
        cfg_mode = 1'($urandom); cfg_base = 10'($urandom);
        cfg_len = 11'($urandom_range(0, 9)); cfg_nbank = 5'($urandom);
      end
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0; stall = 1'b0;
  endtask

  initial begin
    int nr, da;
    //            mode  base     len    nb    mask        abort rest reads done
    vecs[0] = '{1'b0, 10'h010, 11'd4, 5'd0,  32'h0,       -1,  -1,  4,  7};
    vecs[1] = '{1'b1, 10'h3FE, 11'd2, 5'd3,  32'h0,       -1,   4,  6,  9};
    vecs[2] = '{1'b0, 10'h100, 11'd5, 5'd1,  32'h18,      -1,  -1,  5, 10};
    vecs[3] = '{1'b0, 10'h055, 11'd0, 5'd0,  32'h0,       -1,  -1,  0,  3};
    vecs[4] = '{1'b0, 10'h200, 11'd8, 5'd0,  32'h0,        4,  -1,  3, -1};
    vecs[5] = '{1'b1, 10'h020, 11'd3, 5'd0,  32'h0,       -1,  -1,  3,  6};
    vecs[6] = '{1'b1, 10'h3F0, 11'd1, 5'd20, 32'h0,       -1,  -1, 16, 19};
    vecs[7] = '{1'b0, 10'h3FF, 11'd2, 5'd0,  32'h0,        0,  -1,  2,  5};
    vecs[8] = '{1'b0, 10'h000, 11'd3, 5'd0,  32'h2,       -1,  -1,  3,  6};
    vecs[9] = '{1'b1, 10'h000, 11'd2, 5'd2,  32'h8,       -1,  -1,  4,  8};

    repeat (3) @(negedge clk);
    check("reset_state", 0, all_outputs(), 384'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].mode, vecs[i].base, vecs[i].len, vecs[i].nb, vecs[i].abort_at,
             vecs[i].restart_at, 1'b0, vecs[i].mask, nr, da);
      check($sformatf("vec%0d_reads", i), 0, 384'(nr), 384'(vecs[i].exp_reads));
      check($sformatf("vec%0d_done_cycle", i), 0, 384'(da), 384'(vecs[i].exp_done));
    end

    for (int r = 0; r < 24; r++) begin
      run_op(1'($urandom), 10'($urandom), 11'($urandom_range(0, 4)), 5'($urandom_range(0, 20)),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 14)) : -1,
             ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8)) : -1,
             1'b1, 32'h0, nr, da);
    end

    // Asynchronous reset in the middle of a transconv sweep.
    @(negedge clk);
    cfg_mode = 1'b1; cfg_base = 10'h123; cfg_len = 11'd8; cfg_nbank = 5'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_busy", 0, 384'(busy), 384'd1);
    #2 rst_n = 1'b0;
    #1 check("reset_async", 0, all_outputs(), 384'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    prev_sel = '0;
    repeat (2) @(negedge clk);
    check("reset_idle", 0, all_outputs(), 384'd0);

    // Fresh job after reset must run normally.
    run_op(1'b0, 10'h3FE, 11'd3, 5'd0, -1, 2, 1'b0, 32'h0, nr, da);
    check("post_reset_reads", 0, 384'(nr), 384'd3);
    check("post_reset_done_cycle", 0, 384'(da), 384'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
